seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Parametrised serial sequence detector; next generation of the fixed 3-bit "110" Mealy detector.
//  Samples one serial bit per enabled clock and flags when the last LEN bits equal a pattern.
//  Pattern is runtime-loadable, with overlapping/non-overlapping mode, a registered match copy
//  and a saturating match counter. Sits on the serial input path ahead of control logic.
// PARAMETERS
//  LEN      3        pattern length in bits; legal range 2..32
//  PATTERN  3'b110   pattern register reset value, LEN bits; MSB is the first bit received
//  CNT_W    8        width of match_cnt
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      async active-low reset; 0 = reset
//  en         in   1      bit valid: a is sampled this cycle
//  a          in   1      serial data bit
//  overlap    in   1      1 = overlapping detection, 0 = non-overlapping; sampled when en=1
//  pat_load   in   1      load pat_in into the pattern register
//  pat_in     in   LEN    new pattern; MSB is the first bit
//  clear      in   1      synchronous clear of match_cnt and cnt_sat
//  z          out  1      combinational (Mealy) match for the bit sampled this cycle
//  z_q        out  1      z registered; one clock later
//  match_cnt  out  CNT_W  number of matches, saturating
//  cnt_sat    out  1      sticky; match_cnt has reached all-ones
// BEHAVIOUR
//  Reset (rst=0, asynchronous): hist=0, fill=0, pat=PATTERN, z_q=0, match_cnt=0, cnt_sat=0.
//    z evaluates to 0 because fill=0.
//  State: hist[LEN-1:0] holds the last bits, newest in the LSB. fill counts valid bits, 0..LEN.
//  FSM view: FILL (fill<LEN) -> ARMED (fill==LEN). Each en bit in FILL increments fill.
//    ARMED holds while en bits arrive.
//  cand = {hist[LEN-2:0], a}.
//  z = en & ~pat_load & (fill >= LEN-1) & (cand == pat). Same cycle as the final bit; no latency.
//  On en=1 (without pat_load): hist <= cand; fill <= min(fill+1, LEN).
//  On a match with overlap=1, history is kept. The next match can come as soon as the next
//    bit completes the pattern.
//  On a match with overlap=0: fill <= 0. The next match needs LEN fresh bits.
//  en=0: hist, fill and the counter hold; z=0.
//  z_q <= z every clock.
//  pat_load=1: pat <= pat_in; hist <= 0; fill <= 0.
//    pat_load has priority over en: that cycle's bit is discarded and z=0.
//  Counter: on z=1, match_cnt <= match_cnt+1, except at all-ones, where it holds.
//    cnt_sat <= 1 when the count reaches all-ones; cnt_sat stays set until clear or reset.
//  clear=1: match_cnt <= 0; cnt_sat <= 0.
//    clear wins over a coincident match: that match is not counted, but z and z_q still assert.
//    clear does not touch hist, fill or pat.
//  Reset mid-stream: all state goes to its reset value immediately, independent of clk.
//    The first en bit after rst deasserts starts from fill=0.
//  Widths: fill is $clog2(LEN+1) bits. All compares are unsigned. No X may propagate from
//    hist bits that have not yet been filled.
// TESTING
//  T1 default pattern 110, overlap=1: a=1,1,0 on en cycles -> z=1 on the 3rd bit only; z_q=1 a
//     cycle later; match_cnt=1.
//  T2 pat_load pat_in=101, overlap=1: stream 1,0,1,0,1 -> z on bits 3 and 5; match_cnt=2.
//     Same stream with overlap=0 -> z on bit 3 only; match_cnt=1.
//  T3 en gaps: pattern 110 with en=0 cycles between the bits (a toggling while en=0) -> one
//     match on the 3rd enabled bit; z=0 on every en=0 cycle.
//  T4 CNT_W=2, pattern 11, overlap=1: seven consecutive 1s -> 6 matches; match_cnt stops at 3
//     with cnt_sat=1. Then clear coincident with a match -> match_cnt=0, cnt_sat=0, z=1.
//  T5 pat_load in the same cycle as an en bit that would complete the match -> z=0, fill=0.
//     LEN fresh bits are then needed before any match.
//  T6 async reset asserted between clock edges mid-stream (fill=2, cnt=5) -> outputs and state
//     clear with no clk edge. After release, the pattern matches PATTERN again.

Source files
------------

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial sequence detector with loadable pattern and match counter
// Mealy match on the last LEN enabled bits; registered copy and saturating match count.
module seq_detector_param #(
  parameter int             LEN     = 3,
  parameter logic [LEN-1:0] PATTERN = 3'b110,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [LEN-1:0]   pat_in,
  input  logic             clear,
  output logic             z,
  output logic             z_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int FW = $clog2(LEN + 1);

  typedef enum logic {S_FILL, S_ARMED} state_t;

  // Only the LEN-1 most recent bits matter: the oldest bit shifts out when the candidate forms.
  logic [LEN-2:0]   r_hist;
  logic [LEN-2:0]   w_hist_nxt;
  logic [FW-1:0]    r_fill;
  logic [FW-1:0]    w_fill_nxt;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN-1:0]   r_pat;
  logic [LEN-1:0]   w_cand;
  logic             w_z;
  logic             r_z_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic             w_cnt_full;
  logic             w_cnt_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FILL;
      r_hist  <= '0;
      r_fill  <= '0;
      r_pat   <= PATTERN;
    end else begin
      r_state <= w_state_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      if (pat_load) r_pat <= pat_in;
    end
  end

  always_comb begin
    w_cand      = {r_hist, a};
    w_z         = en & ~pat_load & (r_fill >= FW'(LEN - 1)) & (w_cand == r_pat);
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    w_state_nxt = r_state;
    if (pat_load) begin
      w_hist_nxt  = '0;
      w_fill_nxt  = '0;
      w_state_nxt = S_FILL;
    end else if (en) begin
      w_hist_nxt = w_cand[LEN-2:0];
      if (w_z && !overlap) begin
        // Non-overlapping: the matched bits are consumed, so refill from scratch.
        w_fill_nxt  = '0;
        w_state_nxt = S_FILL;
      end else if (r_state == S_FILL) begin
        w_fill_nxt  = r_fill + FW'(1);
        w_state_nxt = (r_fill == FW'(LEN - 1)) ? S_ARMED : S_FILL;
      end
    end
  end

  assign w_cnt_full = &r_cnt;
  assign w_cnt_last = (r_cnt == {{(CNT_W-1){1'b1}}, 1'b0});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_z_q <= 1'b0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else begin
      r_z_q <= w_z;
      // clear beats a coincident match; the match still shows on z and z_q.
      if (clear) begin
        r_cnt <= '0;
        r_sat <= 1'b0;
      end else if (w_z && !w_cnt_full) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_cnt_last) r_sat <= 1'b1;
      end
    end
  end

  assign z         = w_z;
  assign z_q       = r_z_q;
  assign match_cnt = r_cnt;
  assign cnt_sat   = r_sat;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed self-checking bench for seq_detector_param
// Two instances: default LEN=3 detector and a LEN=2, CNT_W=2 one for saturation.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, a = 1'b0, overlap = 1'b1, pat_load = 1'b0, clear = 1'b0;
  logic [2:0] pat_in = 3'b000;
  logic       z, z_q, cnt_sat;
  logic [7:0] match_cnt;

  logic       en2 = 1'b0, a2 = 1'b0, clear2 = 1'b0;
  logic [1:0] pat_in2 = 2'b00;
  logic       z2, z_q2, cnt_sat2;
  logic [1:0] match_cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.LEN(3), .PATTERN(3'b110), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .overlap(overlap), .pat_load(pat_load),
    .pat_in(pat_in), .clear(clear), .z(z), .z_q(z_q), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  seq_detector_param #(.LEN(2), .PATTERN(2'b11), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .a(a2), .overlap(1'b1), .pat_load(1'b0),
    .pat_in(pat_in2), .clear(clear2), .z(z2), .z_q(z_q2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle on dut: drive at negedge, check z mid-cycle, z_q just after the edge.
  task automatic step(input logic e, input logic av, input logic ez, input string tag);
    @(negedge clk);
    en = e;
    a  = av;
    #2 chk({tag, "_z"}, {31'd0, z}, {31'd0, ez});
    @(posedge clk);
    #1 chk({tag, "_zq"}, {31'd0, z_q}, {31'd0, ez});
  endtask

  task automatic step2(input logic e, input logic av, input logic ez, input string tag);
    @(negedge clk);
    en2 = e;
    a2  = av;
    #2 chk({tag, "_z"}, {31'd0, z2}, {31'd0, ez});
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_z", {31'd0, z}, 0);
    chk("rst_zq", {31'd0, z_q}, 0);
    chk("rst_cnt", {24'd0, match_cnt}, 0);
    chk("rst_sat", {31'd0, cnt_sat}, 0);
    chk("rst_cnt2", {30'd0, match_cnt2}, 0);
    @(negedge clk);
    rst = 1'b1;

    // T4: LEN=2 pattern 11, seven 1s -> 6 matches, count saturates at 3
    step2(1, 1, 0, "t4_b1");
    for (int i = 0; i < 6; i++) step2(1, 1, 1, "t4_bn");
    chk("t4_cnt", {30'd0, match_cnt2}, 3);
    chk("t4_sat", {31'd0, cnt_sat2}, 1);
    clear2 = 1'b1;
    step2(1, 1, 1, "t4_clr");
    clear2 = 1'b0;
    chk("t4_clr_cnt", {30'd0, match_cnt2}, 0);
    chk("t4_clr_sat", {31'd0, cnt_sat2}, 0);
    step2(0, 0, 0, "t4_idle");

    // T1: default pattern 110
    step(1, 1, 0, "t1_b1");
    step(1, 1, 0, "t1_b2");
    step(1, 0, 1, "t1_b3");
    chk("t1_cnt", {24'd0, match_cnt}, 1);
    step(0, 0, 0, "t1_idle");

    // T2: pattern 101, overlap then non-overlap
    pat_load = 1'b1; pat_in = 3'b101; clear = 1'b1;
    step(0, 0, 0, "t2_ld");
    pat_load = 1'b0; clear = 1'b0;
    step(1, 1, 0, "t2o_b1");
    step(1, 0, 0, "t2o_b2");
    step(1, 1, 1, "t2o_b3");
    step(1, 0, 0, "t2o_b4");
    step(1, 1, 1, "t2o_b5");
    chk("t2o_cnt", {24'd0, match_cnt}, 2);
    pat_load = 1'b1; clear = 1'b1; overlap = 1'b0;
    step(0, 0, 0, "t2_ld2");
    pat_load = 1'b0; clear = 1'b0;
    step(1, 1, 0, "t2n_b1");
    step(1, 0, 0, "t2n_b2");
    step(1, 1, 1, "t2n_b3");
    step(1, 0, 0, "t2n_b4");
    step(1, 1, 0, "t2n_b5");
    chk("t2n_cnt", {24'd0, match_cnt}, 1);

    // T3: pattern 110 with en gaps; a=0 while en=0 would otherwise complete it
    overlap = 1'b1; pat_load = 1'b1; pat_in = 3'b110; clear = 1'b1;
    step(0, 0, 0, "t3_ld");
    pat_load = 1'b0; clear = 1'b0;
    step(1, 1, 0, "t3_b1");
    step(0, 0, 0, "t3_g1");
    step(0, 1, 0, "t3_g2");
    step(1, 1, 0, "t3_b2");
    step(0, 0, 0, "t3_g3");
    step(0, 1, 0, "t3_g4");
    step(1, 0, 1, "t3_b3");
    chk("t3_cnt", {24'd0, match_cnt}, 1);

    // T5: pat_load on the completing bit discards it and empties history
    clear = 1'b1;
    step(0, 0, 0, "t5_clr");
    clear = 1'b0;
    step(1, 1, 0, "t5_b1");
    step(1, 1, 0, "t5_b2");
    pat_load = 1'b1; pat_in = 3'b110;
    step(1, 0, 0, "t5_ld");
    pat_load = 1'b0;
    step(1, 0, 0, "t5_f1");
    step(1, 1, 0, "t5_f2");
    step(1, 1, 0, "t5_f3");
    step(1, 0, 1, "t5_f4");
    chk("t5_cnt", {24'd0, match_cnt}, 1);

    // T6: pattern 101 non-overlap to cnt=5, fill=2, then async reset mid-cycle
    pat_load = 1'b1; pat_in = 3'b101; clear = 1'b1; overlap = 1'b0;
    step(0, 0, 0, "t6_ld");
    pat_load = 1'b0; clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, "t6_r1");
      step(1, 0, 0, "t6_r2");
      step(1, 1, 1, "t6_r3");
    end
    chk("t6_cnt5", {24'd0, match_cnt}, 5);
    step(1, 1, 0, "t6_p1");
    step(1, 0, 0, "t6_p2");
    @(negedge clk);
    en = 1'b1; a = 1'b1;
    #1 chk("t6_pre_z", {31'd0, z}, 1);
    #1 rst = 1'b0;
    #1;
    chk("t6_async_z", {31'd0, z}, 0);
    chk("t6_async_cnt", {24'd0, match_cnt}, 0);
    chk("t6_async_zq", {31'd0, z_q}, 0);
    chk("t6_async_sat", {31'd0, cnt_sat}, 0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    overlap = 1'b1;
    step(1, 1, 0, "t6_a1");
    step(1, 1, 0, "t6_a2");
    step(1, 0, 1, "t6_a3");
    chk("t6_after_cnt", {24'd0, match_cnt}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
